feature_frame_assembler: RTL and testbench

FEATURE_FRAME_ASSEMBLER -- requirements
Module: feature_frame_assembler

---
 rtl/feat_pkg.sv | 15 +
 rtl/feature_frame_assembler_if.sv | 30 +++
 rtl/feature_frame_assembler.sv | 141 ++++++++++++++
 tb/tb_feature_frame_assembler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/feat_pkg.sv
// rtl/feat_pkg.sv - shared sizes, kept-feature mask and FSM states for the frame assembler
package feat_pkg;

    localparam int FEAT_W   = 8;
    localparam int NUM_FEAT = 7;

    // Only these feature indices feed the downstream decision tree.
    localparam logic [NUM_FEAT-1:0] KEEP_MASK = 7'b111_0011;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/feature_frame_assembler_if.sv
// rtl/feature_frame_assembler_if.sv - beat input, feature output and status bundle of the assembler
interface feature_frame_assembler_if #(
    parameter int FEAT_W = feat_pkg::FEAT_W
);

    logic              in_valid;
    logic              in_ready;
    logic [FEAT_W-1:0] in_data;
    logic              in_last;
    logic [FEAT_W-1:0] X0;
    logic [FEAT_W-1:0] X1;
    logic [FEAT_W-1:0] X4;
    logic [FEAT_W-1:0] X5;
    logic [FEAT_W-1:0] X6;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, X0, X1, X4, X5, X6, out_valid, frame_err, frame_cnt
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, X0, X1, X4, X5, X6, out_valid, frame_err, frame_cnt
    );

endinterface

// File: rtl/feature_frame_assembler.sv
// rtl/feature_frame_assembler.sv - collects indexed feature beats into a registered frame for the classifier
module feature_frame_assembler #(
    parameter int FEAT_W   = feat_pkg::FEAT_W,
    parameter int NUM_FEAT = feat_pkg::NUM_FEAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    feature_frame_assembler_if.slave   bus
);

    import feat_pkg::state_t;
    import feat_pkg::ST_COLLECT;
    import feat_pkg::ST_HOLD;
    import feat_pkg::KEEP_MASK;

    localparam int              IDX_W    = $clog2(NUM_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [FEAT_W-1:0]  shadow_q [NUM_FEAT];
    logic [FEAT_W-1:0]  shadow_d [NUM_FEAT];
    logic [FEAT_W-1:0]  x0_q, x1_q, x4_q, x5_q, x6_q;
    logic [FEAT_W-1:0]  x0_d, x1_d, x4_d, x5_d, x6_d;
    logic               accept;
    logic               at_last;
    logic               transfer;

    assign accept  = bus.in_valid && in_ready_q;
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x4_d        = x4_q;
        x5_d        = x5_q;
        x6_d        = x6_q;
        transfer    = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (KEEP_MASK[idx_q]) begin
                        shadow_d[idx_q] = bus.in_data;
                    end
                    if (at_last && bus.in_last) begin
                        idx_d = '0;
                        if (!out_valid_q || bus.out_ready) begin
                            transfer = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else if (at_last || bus.in_last) begin
                        // Length mismatch either way: the partial frame is abandoned.
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    transfer = 1'b1;
                    state_d  = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase

        // shadow_d already carries the final beat when the frame completes in COLLECT.
        if (transfer) begin
            x0_d        = shadow_d[0];
            x1_d        = shadow_d[1];
            x4_d        = shadow_d[4];
            x5_d        = shadow_d[5];
            x6_d        = shadow_d[6];
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 16'd1;
        end

        in_ready_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x4_q        <= '0;
            x5_q        <= '0;
            x6_q        <= '0;
            for (int i = 0; i < NUM_FEAT; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            cnt_q       <= cnt_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x4_q        <= x4_d;
            x5_q        <= x5_d;
            x6_q        <= x6_d;
            shadow_q    <= shadow_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.frame_cnt = cnt_q;
    assign bus.X0        = x0_q;
    assign bus.X1        = x1_q;
    assign bus.X4        = x4_q;
    assign bus.X5        = x5_q;
    assign bus.X6        = x6_q;

endmodule

// File: tb/tb_feature_frame_assembler.sv
// tb/tb_feature_frame_assembler.sv - scoreboard bench for feature_frame_assembler
module tb_feature_frame_assembler;

    localparam int NF = 7;

    typedef struct {
        logic [7:0]  x0, x1, x4, x5, x6;
        logic [15:0] cnt;
    } frame_t;

    logic clk;
    logic rst_n;
    int   ntests = 0;
    int   nfail  = 0;
    bit   rnd_mode = 0;

    frame_t      exp_q[$];
    logic [7:0]  acc[$];
    logic [15:0] m_cnt = 0;
    int          exp_err = 0;
    int          seen_err = 0;
    bit          stable_chk = 0;
    logic [39:0] held;

    feature_frame_assembler_if #(.FEAT_W(8)) bus ();

    feature_frame_assembler #(.FEAT_W(8), .NUM_FEAT(NF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: model frames from accepted beats, compare on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc.delete();
            exp_q.delete();
            m_cnt      = 0;
            stable_chk = 0;
        end else begin
            if (bus.out_valid) begin
                if (stable_chk)
                    chk("x_stable", {bus.X0, bus.X1, bus.X4, bus.X5, bus.X6}, held);
                if (bus.out_ready) begin
                    chk("scoreboard_nonempty", 40'(exp_q.size() != 0), 40'd1);
                    if (exp_q.size() != 0) begin
                        frame_t e;
                        e = exp_q.pop_front();
                        chk("X0", bus.X0, e.x0);
                        chk("X1", bus.X1, e.x1);
                        chk("X4", bus.X4, e.x4);
                        chk("X5", bus.X5, e.x5);
                        chk("X6", bus.X6, e.x6);
                        chk("frame_cnt", bus.frame_cnt, e.cnt);
                    end
                    stable_chk = 0;
                end else begin
                    stable_chk = 1;
                    held = {bus.X0, bus.X1, bus.X4, bus.X5, bus.X6};
                end
            end else begin
                if (stable_chk) chk("out_valid_held", 40'd0, 40'd1);
                stable_chk = 0;
            end
            if (bus.frame_err) seen_err++;
            if (bus.in_valid && bus.in_ready) begin
                acc.push_back(bus.in_data);
                if (bus.in_last) begin
                    if (acc.size() == NF) begin
                        frame_t f;
                        m_cnt = m_cnt + 16'd1;
                        f.x0 = acc[0]; f.x1 = acc[1]; f.x4 = acc[4];
                        f.x5 = acc[5]; f.x6 = acc[6]; f.cnt = m_cnt;
                        exp_q.push_back(f);
                    end else begin
                        exp_err++;
                    end
                    acc.delete();
                end else if (acc.size() == NF) begin
                    exp_err++;
                    acc.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!ok) chk("send_beat_timeout", 40'd0, 40'd1);
    endtask

    task automatic send_frame(input int len, input bit last_end, input logic [7:0] base, input bit rnd_data);
        for (int i = 0; i < len; i++) begin
            send_beat(rnd_data ? 8'($urandom) : base + 8'(i), last_end && (i == len - 1));
            if (rnd_mode) idle($urandom_range(0, 2));
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_x", {bus.X0, bus.X1, bus.X4, bus.X5, bus.X6}, 40'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_low_after_release", bus.in_ready, 0);
        tick();
        chk("in_ready_rise", bus.in_ready, 1);
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        do_reset();

        // Single frame, immediate delivery
        bus.out_ready = 1'b1;
        for (int i = 0; i < NF; i++) begin
            send_beat(8'h10 + 8'(i), i == NF - 1);
            if (i == NF - 2) chk("ov_before_last", bus.out_valid, 0);
        end
        chk("ov_after_last", bus.out_valid, 1);
        chk("d_X0", bus.X0, 8'h10);
        chk("d_X1", bus.X1, 8'h11);
        chk("d_X4", bus.X4, 8'h14);
        chk("d_X5", bus.X5, 8'h15);
        chk("d_X6", bus.X6, 8'h16);
        chk("d_cnt1", bus.frame_cnt, 1);
        idle(2);

        // Back-to-back frames with a stalled consumer
        do_reset();
        bus.out_ready = 1'b0;
        send_frame(NF, 1, 8'h20, 0);
        send_frame(NF, 1, 8'h30, 0);
        chk("hold_in_ready", bus.in_ready, 0);
        chk("hold_out_valid", bus.out_valid, 1);
        chk("hold_x6_old", bus.X6, 8'h26);
        idle(1);
        chk("hold_in_ready_2", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        idle(1);
        chk("hold_x6_new", bus.X6, 8'h36);
        chk("hold_cnt2", bus.frame_cnt, 2);
        chk("hold_ov_kept", bus.out_valid, 1);
        chk("hold_in_ready_back", bus.in_ready, 1);
        idle(1);
        chk("ov_fall_after_hs", bus.out_valid, 0);

        // Early last
        send_frame(5, 1, 8'h40, 0);
        chk("early_err_pulse", bus.frame_err, 1);
        idle(1);
        chk("early_err_single", bus.frame_err, 0);
        chk("early_ov", bus.out_valid, 0);
        send_frame(NF, 1, 8'h50, 0);
        chk("early_next_X5", bus.X5, 8'h55);
        chk("early_next_cnt", bus.frame_cnt, 3);

        // Missing last
        idle(1);
        send_frame(NF, 0, 8'h60, 0);
        chk("nolast_err_pulse", bus.frame_err, 1);
        send_frame(NF, 1, 8'hA0, 0);
        chk("nolast_next_X0", bus.X0, 8'hA0);
        chk("nolast_next_X6", bus.X6, 8'hA6);
        chk("nolast_next_cnt", bus.frame_cnt, 4);

        // Reset mid-frame with a frame parked in the output
        idle(1);
        bus.out_ready = 1'b0;
        send_frame(NF, 1, 8'hB0, 0);
        send_frame(3, 0, 8'hC0, 0);
        do_reset();
        bus.out_ready = 1'b1;
        send_frame(NF, 1, 8'hD0, 0);
        chk("post_rst_X0", bus.X0, 8'hD0);
        chk("post_rst_cnt", bus.frame_cnt, 1);
        idle(2);

        // Counter wrap
        force dut.cnt_q = 16'hFFFF;
        idle(1);
        release dut.cnt_q;
        m_cnt = 16'hFFFF;
        idle(1);
        send_frame(NF, 1, 8'hE0, 0);
        chk("cnt_wrap", bus.frame_cnt, 0);
        idle(2);

        // Randomized traffic and backpressure
        rnd_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0)      send_frame($urandom_range(1, NF - 1), 1, 8'h00, 1);
            else if (kind == 1) send_frame(NF, 0, 8'h00, 1);
            else                send_frame(NF, 1, 8'h00, 1);
        end
        rnd_mode = 0;
        bus.out_ready = 1'b1;
        idle(6);
        chk("scoreboard_drained", 40'(exp_q.size()), 40'd0);
        chk("frame_err_count", 40'(seen_err), 40'(exp_err));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
